// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and key-state payload for the PS/2 keyboard event decoder.
package kbd_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BREAK = 8'hF0;

  localparam logic [BYTE_W-1:0] ASCII_NUL   = 8'h00;
  localparam logic [BYTE_W-1:0] ASCII_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_ZERO  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_LC_A  = 8'h61;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dec_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] code;
    logic              ext;
    logic              down;
  } key_state_t;

  // Offset into the lowercase letter or digit range.
  function automatic logic [BYTE_W-1:0] ascii_ofs(input logic [BYTE_W-1:0] base,
                                                  input int unsigned idx);
    return base + BYTE_W'(idx);
  endfunction

endpackage

// File: rtl/kbd_ascii_rom.sv
// Combinational set-2 scancode to ASCII lookup; extended (E0) keys map to NUL.
module kbd_ascii_rom
  import kbd_pkg::*;
(
  input  logic [BYTE_W-1:0] i_code,
  input  logic              i_ext,
  output logic [BYTE_W-1:0] o_ascii
);

  logic [BYTE_W-1:0] w_ascii;

  always_comb begin
    w_ascii = ASCII_NUL;
    case (i_code)
      8'h1C: w_ascii = ascii_ofs(ASCII_LC_A, 0);
      8'h32: w_ascii = ascii_ofs(ASCII_LC_A, 1);
      8'h21: w_ascii = ascii_ofs(ASCII_LC_A, 2);
      8'h23: w_ascii = ascii_ofs(ASCII_LC_A, 3);
      8'h24: w_ascii = ascii_ofs(ASCII_LC_A, 4);
      8'h2B: w_ascii = ascii_ofs(ASCII_LC_A, 5);
      8'h34: w_ascii = ascii_ofs(ASCII_LC_A, 6);
      8'h33: w_ascii = ascii_ofs(ASCII_LC_A, 7);
      8'h43: w_ascii = ascii_ofs(ASCII_LC_A, 8);
      8'h3B: w_ascii = ascii_ofs(ASCII_LC_A, 9);
      8'h42: w_ascii = ascii_ofs(ASCII_LC_A, 10);
      8'h4B: w_ascii = ascii_ofs(ASCII_LC_A, 11);
      8'h3A: w_ascii = ascii_ofs(ASCII_LC_A, 12);
      8'h31: w_ascii = ascii_ofs(ASCII_LC_A, 13);
      8'h44: w_ascii = ascii_ofs(ASCII_LC_A, 14);
      8'h4D: w_ascii = ascii_ofs(ASCII_LC_A, 15);
      8'h15: w_ascii = ascii_ofs(ASCII_LC_A, 16);
      8'h2D: w_ascii = ascii_ofs(ASCII_LC_A, 17);
      8'h1B: w_ascii = ascii_ofs(ASCII_LC_A, 18);
      8'h2C: w_ascii = ascii_ofs(ASCII_LC_A, 19);
      8'h3C: w_ascii = ascii_ofs(ASCII_LC_A, 20);
      8'h2A: w_ascii = ascii_ofs(ASCII_LC_A, 21);
      8'h1D: w_ascii = ascii_ofs(ASCII_LC_A, 22);
      8'h22: w_ascii = ascii_ofs(ASCII_LC_A, 23);
      8'h35: w_ascii = ascii_ofs(ASCII_LC_A, 24);
      8'h1A: w_ascii = ascii_ofs(ASCII_LC_A, 25);
      // Digit row
      8'h45: w_ascii = ascii_ofs(ASCII_ZERO, 0);
      8'h16: w_ascii = ascii_ofs(ASCII_ZERO, 1);
      8'h1E: w_ascii = ascii_ofs(ASCII_ZERO, 2);
      8'h26: w_ascii = ascii_ofs(ASCII_ZERO, 3);
      8'h25: w_ascii = ascii_ofs(ASCII_ZERO, 4);
      8'h2E: w_ascii = ascii_ofs(ASCII_ZERO, 5);
      8'h36: w_ascii = ascii_ofs(ASCII_ZERO, 6);
      8'h3D: w_ascii = ascii_ofs(ASCII_ZERO, 7);
      8'h3E: w_ascii = ascii_ofs(ASCII_ZERO, 8);
      8'h46: w_ascii = ascii_ofs(ASCII_ZERO, 9);
      8'h29: w_ascii = ASCII_SPACE;
      default: w_ascii = ASCII_NUL;
    endcase
  end

  assign o_ascii = i_ext ? ASCII_NUL : w_ascii;

endmodule

// File: rtl/kbd_event_decoder.sv
// Pops set-2 scancodes from the PS/2 FIFO and tracks a single held key with press/release events.
module kbd_event_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  ps2_data_in,
  input  logic               ps2_ready,
  input  logic               ps2_overflow,
  output logic               nextdata_n,
  output logic [BYTE_W-1:0]  key_code,
  output logic               key_ext,
  output logic [BYTE_W-1:0]  key_ascii,
  output logic               key_down,
  output logic               press_event,
  output logic               release_event,
  output logic [COUNT_W-1:0] press_count,
  output logic               ovf_sticky
);

  dec_state_e   r_state;
  key_state_t   r_key;
  logic         r_ext_pend;
  logic         r_brk_pend;
  logic         r_press;
  logic         r_release;
  logic [COUNT_W-1:0] r_count;
  logic         r_ovf;

  dec_state_e   w_state_nxt;
  key_state_t   w_key_nxt;
  logic         w_ext_pend_nxt;
  logic         w_brk_pend_nxt;
  logic         w_press_nxt;
  logic         w_release_nxt;
  logic [COUNT_W-1:0] w_count_nxt;
  logic         w_pop;
  logic         w_same_key;

  // A byte is consumed in the same cycle it is seen in IDLE; reset blocks the pop.
  assign w_pop      = (r_state == IDLE) && ps2_ready;
  assign nextdata_n = ~(w_pop & ~rst);

  assign w_same_key = r_key.down && (ps2_data_in == r_key.code) && (r_ext_pend == r_key.ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_key      <= w_key_nxt;
      r_ext_pend <= w_ext_pend_nxt;
      r_brk_pend <= w_brk_pend_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_count    <= w_count_nxt;
      r_ovf      <= r_ovf | ps2_overflow;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_key_nxt      = r_key;
    w_ext_pend_nxt = r_ext_pend;
    w_brk_pend_nxt = r_brk_pend;
    w_press_nxt    = 1'b0;
    w_release_nxt  = 1'b0;
    w_count_nxt    = r_count;
    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_state_nxt = WAIT;
          if (ps2_data_in == SC_EXT) begin
            w_ext_pend_nxt = 1'b1;
          end else if (ps2_data_in == SC_BREAK) begin
            w_brk_pend_nxt = 1'b1;
          end else if (r_brk_pend) begin
            // Break of anything other than the tracked key is dropped.
            if (w_same_key) begin
              w_key_nxt.down = 1'b0;
              w_release_nxt  = 1'b1;
            end
            w_ext_pend_nxt = 1'b0;
            w_brk_pend_nxt = 1'b0;
          end else begin
            // Make code; an identical held key is typematic repeat.
            if (!w_same_key) begin
              w_key_nxt.code = ps2_data_in;
              w_key_nxt.ext  = r_ext_pend;
              w_key_nxt.down = 1'b1;
              w_press_nxt    = 1'b1;
              w_count_nxt    = r_count + COUNT_W'(1);
            end
            w_ext_pend_nxt = 1'b0;
          end
        end
      end
      WAIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  kbd_ascii_rom u_ascii_rom (
    .i_code  (r_key.code),
    .i_ext   (r_key.ext),
    .o_ascii (key_ascii)
  );

  assign key_code      = r_key.code;
  assign key_ext       = r_key.ext;
  assign key_down      = r_key.down;
  assign press_event   = r_press;
  assign release_event = r_release;
  assign press_count   = r_count;
  assign ovf_sticky    = r_ovf;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed bench: models the upstream FIFO, counts pops/events and checks key state against hand-computed values.
module tb_kbd_event_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_data_in;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_down;
  logic       press_event;
  logic       release_event;
  logic [7:0] press_count;
  logic       ovf_sticky;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic       pop_pend = 1'b0;
  logic       prev_low = 1'b0;
  int         n_pops = 0;
  int         n_press = 0;
  int         n_rel = 0;
  int         n_adj = 0;
  int         n_bad_pop = 0;
  int         cyc = 0;
  int         first_pop = -1;
  int         last_pop = -1;

  kbd_event_decoder #(.COUNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_data_in   (ps2_data_in),
    .ps2_ready     (ps2_ready),
    .ps2_overflow  (ps2_overflow),
    .nextdata_n    (nextdata_n),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_ascii     (key_ascii),
    .key_down      (key_down),
    .press_event   (press_event),
    .release_event (release_event),
    .press_count   (press_count),
    .ovf_sticky    (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Upstream FIFO model plus pop/event monitor, all in the low phase.
  always @(negedge clk) begin
    cyc++;
    if (pop_pend && q.size() != 0) void'(q.pop_front());
    ps2_ready   = (q.size() != 0);
    ps2_data_in = ps2_ready ? q[0] : 8'h00;
    #1;
    pop_pend = !nextdata_n;
    if (!nextdata_n) begin
      n_pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (prev_low) n_adj++;
      if (!ps2_ready) n_bad_pop++;
    end
    prev_low = !nextdata_n;
    if (press_event) n_press++;
    if (release_event) n_rel++;
  end

  task automatic clr_cnt();
    n_pops = 0; n_press = 0; n_rel = 0; first_pop = -1; last_pop = -1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clr_cnt();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || pop_pend) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 32'(1), 32'(0));
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    q.push_back(b);
  endtask

  initial begin
    rst          = 1'b1;
    ps2_overflow = 1'b0;
    ps2_data_in  = 8'h00;
    ps2_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    clr_cnt();

    // Reset state
    chk("rst_nextdata_n", 32'(nextdata_n), 32'(1));
    chk("rst_key_code", 32'(key_code), 32'h00);
    chk("rst_key_down", 32'(key_down), 32'(0));
    chk("rst_press_count", 32'(press_count), 32'(0));
    chk("rst_ovf", 32'(ovf_sticky), 32'(0));

    // Single make
    send(8'h1C);
    drain(50);
    chk("a_code", 32'(key_code), 32'h1C);
    chk("a_ascii", 32'(key_ascii), 32'h61);
    chk("a_down", 32'(key_down), 32'(1));
    chk("a_press_ev", 32'(n_press), 32'(1));
    chk("a_count", 32'(press_count), 32'(1));
    chk("a_pops", 32'(n_pops), 32'(1));

    // Typematic repeat then break
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain(50);
    chk("rep_count", 32'(press_count), 32'(1));
    chk("rep_press_ev", 32'(n_press), 32'(1));
    chk("rep_rel_ev", 32'(n_rel), 32'(1));
    chk("rep_down", 32'(key_down), 32'(0));
    chk("rep_pops", 32'(n_pops), 32'(5));

    // Extended key; a plain break of the same code must not release it
    do_reset();
    send(8'hE0); send(8'h75);
    drain(50);
    chk("ext_ext", 32'(key_ext), 32'(1));
    chk("ext_code", 32'(key_code), 32'h75);
    chk("ext_ascii", 32'(key_ascii), 32'h00);
    send(8'hF0); send(8'h75);
    drain(50);
    chk("ext_norel", 32'(n_rel), 32'(0));
    chk("ext_still_down", 32'(key_down), 32'(1));
    send(8'hE0); send(8'hF0); send(8'h75);
    drain(50);
    chk("ext_rel", 32'(n_rel), 32'(1));
    chk("ext_up", 32'(key_down), 32'(0));

    // ASCII table spot checks
    do_reset();
    send(8'h29); drain(50); chk("asc_space", 32'(key_ascii), 32'h20);
    send(8'h45); drain(50); chk("asc_0", 32'(key_ascii), 32'h30);
    send(8'h1A); drain(50); chk("asc_z", 32'(key_ascii), 32'h7A);
    send(8'h46); drain(50); chk("asc_9", 32'(key_ascii), 32'h39);
    send(8'h4D); drain(50); chk("asc_p", 32'(key_ascii), 32'h70);
    send(8'h5A); drain(50); chk("asc_unmapped", 32'(key_ascii), 32'h00);
    chk("asc_count", 32'(press_count), 32'(6));

    // Key replacement: earlier key's break ignored
    do_reset();
    send(8'h1C); send(8'h32);
    drain(50);
    chk("repl_code", 32'(key_code), 32'h32);
    chk("repl_count", 32'(press_count), 32'(2));
    send(8'hF0); send(8'h1C);
    drain(50);
    chk("repl_norel", 32'(n_rel), 32'(0));
    chk("repl_down", 32'(key_down), 32'(1));
    send(8'hF0); send(8'h32);
    drain(50);
    chk("repl_rel", 32'(n_rel), 32'(1));

    // Counter wrap after 256 new presses
    do_reset();
    for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h16 : 8'h1E);
    drain(2000);
    chk("wrap_count", 32'(press_count), 32'(0));
    chk("wrap_press_ev", 32'(n_press), 32'(256));
    chk("wrap_code", 32'(key_code), 32'h1E);

    // Pending break discarded by reset
    do_reset();
    send(8'hF0);
    drain(50);
    do_reset();
    send(8'h1C);
    drain(50);
    chk("rstbrk_down", 32'(key_down), 32'(1));
    chk("rstbrk_count", 32'(press_count), 32'(1));
    chk("rstbrk_rel", 32'(n_rel), 32'(0));

    // Byte presented during reset is not popped
    @(posedge clk); #2;
    rst = 1'b1;
    clr_cnt();
    send(8'h32);
    repeat (4) @(posedge clk);
    #2;
    chk("rsthold_pops", 32'(n_pops), 32'(0));
    chk("rsthold_q", 32'(q.size()), 32'(1));
    rst = 1'b0;
    drain(50);
    chk("rsthold_code", 32'(key_code), 32'h32);
    chk("rsthold_count", 32'(press_count), 32'(1));

    // Back-to-back FIFO throughput and sticky overflow
    do_reset();
    n_adj = 0; n_bad_pop = 0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    drain(50);
    chk("thr_pops", 32'(n_pops), 32'(4));
    chk("thr_span", 32'(last_pop - first_pop), 32'(6));
    chk("thr_adjacent", 32'(n_adj), 32'(0));
    chk("thr_pop_not_ready", 32'(n_bad_pop), 32'(0));
    chk("thr_count", 32'(press_count), 32'(4));
    chk("ovf_before", 32'(ovf_sticky), 32'(0));
    ps2_overflow = 1'b1;
    @(posedge clk); #2;
    ps2_overflow = 1'b0;
    chk("ovf_set", 32'(ovf_sticky), 32'(1));
    repeat (5) @(posedge clk); #2;
    chk("ovf_hold", 32'(ovf_sticky), 32'(1));
    chk("ovf_fsm_idle", 32'(nextdata_n), 32'(1));
    do_reset();
    chk("ovf_cleared", 32'(ovf_sticky), 32'(0));
    chk("rst_count_clr", 32'(press_count), 32'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_event_decoder.md
KBD_EVENT_DECODER -- requirements
Module: kbd_event_decoder

Interface
REQ-001 Parameter: COUNT_W, default 8, width of the press counter.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ps2_data_in  input  8  scancode byte at head of upstream ps2_keyboard FIFO; valid only while ps2_ready=1.
REQ-005 ps2_ready  input  1  upstream FIFO non-empty.
REQ-006 ps2_overflow  input  1  upstream FIFO overflow flag.
REQ-007 nextdata_n  output  1  active-low pop strobe to upstream; one-cycle low pulse per consumed byte.
REQ-008 key_code  output  8  set-2 scancode of current/last pressed key.
REQ-009 key_ext  output  1  current/last key carried an E0 prefix.
REQ-010 key_ascii  output  8  ASCII of key_code; 8'h00 when unmapped or key_ext=1.
REQ-011 key_down  output  1  high while the key in key_code is held.
REQ-012 press_event  output  1  one-cycle pulse on each new (non-repeat) press.
REQ-013 release_event  output  1  one-cycle pulse on each release of the held key.
REQ-014 press_count  output  COUNT_W  number of new presses since reset, modulo 2^COUNT_W.
REQ-015 ovf_sticky  output  1  set when ps2_overflow seen; cleared only by rst.

Function
REQ-016 FSM states: IDLE, WAIT; IDLE with ps2_ready=1 captures ps2_data_in and drives nextdata_n=0 in that cycle, then goes to WAIT.
REQ-017 WAIT lasts exactly one cycle, nextdata_n=1, then IDLE; max throughput one byte per two cycles.
REQ-018 nextdata_n SHALL never be low for two consecutive cycles nor while ps2_ready=0.
REQ-019 Byte captured at cycle N: all output/flag updates registered and visible at N+1; event pulses high only in N+1.
REQ-020 Byte 8'hE0: set ext_pending; no output change.
REQ-021 Byte 8'hF0: set break_pending; no output change; ext_pending retained.
REQ-022 Other byte X with break_pending=1: if key_down=1, X==key_code and ext_pending==key_ext then key_down=0 and pulse release_event; otherwise ignore; clear both pending flags.
REQ-023 Other byte X with break_pending=0: if key_down=1, X==key_code and ext_pending==key_ext it is typematic repeat -- no change, no pulse; else load key_code=X, key_ext=ext_pending, key_down=1, pulse press_event, increment press_count; clear ext_pending.
REQ-024 press_count wraps from 2^COUNT_W-1 to 0 with no flag.
REQ-025 New press while another key held replaces it (single-key tracking); earlier key's break is then ignored per REQ-022.
REQ-026 key_ascii combinational from key_code/key_ext: letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 'a'..'z' (lowercase); digits 45,16,1E,26,25,2E,36,3D,3E,46 -> '0'..'9'; 29 -> 8'h20; all else 8'h00.
REQ-027 ps2_overflow=1 in any cycle sets ovf_sticky at next edge; does not alter FSM.

Reset
REQ-028 rst=1 at an edge: state=IDLE, nextdata_n=1, key_code=0, key_ext=0, key_down=0, press_event=0, release_event=0, press_count=0, ovf_sticky=0, both pending flags cleared.
REQ-029 rst takes priority over all inputs; a byte presented during rst is not popped and remains for the first post-reset IDLE cycle.
REQ-030 rst during WAIT or with prefixes pending discards the partial sequence.

Structure
REQ-031 Shared package kbd_pkg holds SC_EXT=8'hE0, SC_BREAK=8'hF0, FSM state encoding, and ASCII constants.
REQ-032 Scancode-to-ASCII table is a sub-module kbd_ascii_rom (purely combinational); FSM, flags and counter in kbd_event_decoder.

Verification
REQ-033 Bytes 1C -> key_code=1C, key_ascii=8'h61, key_down=1, one press_event, press_count=1, nextdata_n low exactly once.
REQ-034 Bytes 1C,1C,1C then F0,1C -> press_count=1, one press_event, one release_event, key_down=0 after final byte.
REQ-035 Bytes E0,75 -> key_ext=1, key_code=75, key_ascii=00; then F0,75 (no E0) -> no release, key_down stays 1.
REQ-036 256 alternating presses of 16/1E (no breaks) with COUNT_W=8 -> press_count returns to 0, 256 press_event pulses.
REQ-037 Feed F0, assert rst one cycle, then 1C -> treated as make: key_down=1, press_count=1.
REQ-038 ps2_ready held high with 4 queued bytes -> nextdata_n pulses every other cycle, never adjacent; pulse ps2_overflow once -> ovf_sticky=1 until rst.
